// File: rtl/gbe_cpu_attach_v2.sv
// gbe_cpu_attach_v2: OPB slave between the PowerPC and the GbE UDP core.
// Transaction FSM gives registered RAMs a read latency slot and performs
// byte-lane read-modify-write on the TX buffer and ARP cache. Also provides
// address-error acks, RX/TX packet counters and an optional interrupt.
// Optional feature macro: GBE_CPU_IRQ_EN (irq_status/irq_mask regs + irq).
module gbe_cpu_attach_v2 #(
  parameter logic [31:0] C_BASEADDR      = 32'h0,
  parameter logic [31:0] C_HIGHADDR      = 32'h3FFF,
  parameter logic [47:0] LOCAL_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [31:0] LOCAL_IP        = 32'hFFFF_FFFF,
  parameter logic [15:0] LOCAL_PORT      = 16'hFFFF,
  parameter int          LOCAL_GATEWAY   = 0,
  parameter logic        LOCAL_ENABLE    = 1'b0,
  parameter logic        CPU_PROMISCUOUS = 1'b0,
  parameter logic [31:0] PHY_CONFIG      = 32'd0,
  parameter int          BUF_AW          = 9,
  parameter int          ARP_AW          = 8
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst,
  input  logic                OPB_RNW,
  input  logic                OPB_select,
  input  logic [3:0]          OPB_BE,
  input  logic [31:0]         OPB_ABus,
  input  logic [31:0]         OPB_DBus,
  output logic [31:0]         Sl_DBus,
  output logic                Sl_xferAck,
  output logic                Sl_errAck,
  output logic                Sl_retry,
  output logic                Sl_toutSup,
  output logic                local_enable,
  output logic [47:0]         local_mac,
  output logic [31:0]         local_ip,
  output logic [15:0]         local_port,
  output logic [ARP_AW-1:0]   local_gateway,
  output logic                cpu_promiscuous,
  output logic [ARP_AW-1:0]   arp_cache_addr,
  input  logic [47:0]         arp_cache_rd_data,
  output logic [47:0]         arp_cache_wr_data,
  output logic                arp_cache_wr_en,
  output logic [BUF_AW-1:0]   cpu_rx_buffer_addr,
  input  logic [31:0]         cpu_rx_buffer_rd_data,
  input  logic [BUF_AW+2:0]   cpu_rx_size,
  input  logic                cpu_rx_ready,
  output logic                cpu_rx_ack,
  output logic [BUF_AW-1:0]   cpu_tx_buffer_addr,
  input  logic [31:0]         cpu_tx_buffer_rd_data,
  output logic [31:0]         cpu_tx_buffer_wr_data,
  output logic                cpu_tx_buffer_wr_en,
  output logic [BUF_AW+2:0]   cpu_tx_size,
  output logic                cpu_tx_ready,
  input  logic                cpu_tx_done,
  input  logic [31:0]         phy_status,
  output logic [31:0]         phy_control,
  output logic                irq
);

  localparam logic [1:0] S_IDLE = 2'd0, S_RD_WAIT = 2'd1, S_RMW = 2'd2, S_ACK = 2'd3;
  localparam logic [1:0] W_REG = 2'd0, W_TX = 2'd1, W_RX = 2'd2, W_ARP = 2'd3;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              sel_d_q;
  logic [1:0]        win_q, win_d;
  logic [10:2]       off_q, off_d;
  logic              rnw_q, rnw_d, err_q, err_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [47:0]       mac_q, mac_d;
  logic [31:0]       ip_q, ip_d, phy_q, phy_d;
  logic [15:0]       port_q, port_d, rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [ARP_AW-1:0] gw_q, gw_d;
  logic              en_q, en_d, prom_q, prom_d;
  logic [BUF_AW+2:0] rx_size_q, rx_size_d, tx_size_q, tx_size_d;
  logic              rx_ack_q, rx_ack_d, tx_rdy_q, tx_rdy_d;
`ifdef GBE_CPU_IRQ_EN
  logic [1:0]        irq_st_q, irq_st_d, irq_mk_q, irq_mk_d;
  logic              irq_q, irq_d;
`endif

  logic [13:2] off_in;
  logic        start, bad, ack_cyc, xfer, wr_cyc, reg_wr, rx_latch;
  logic [31:0] reg_rd, mrg, rd_mux, arp_lo;
  logic [15:0] arp_hi;

  assign off_in  = 12'((OPB_ABus - C_BASEADDR) >> 2);
  assign start   = OPB_select && !sel_d_q && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign ack_cyc = (state_q == S_ACK);
  assign xfer    = ack_cyc && !err_q;
  assign wr_cyc  = xfer && !rnw_q;
  assign reg_wr  = wr_cyc && (win_q == W_REG);
  assign rx_latch = cpu_rx_ready && rx_ack_q;

  // Register readback for the latched word index
  always_comb begin
    reg_rd = 32'd0;
    case (off_q)
      9'd0:  reg_rd = {16'd0, mac_q[47:32]};
      9'd1:  reg_rd = mac_q[31:0];
      9'd3:  reg_rd = 32'(gw_q);
      9'd4:  reg_rd = ip_q;
      9'd6:  reg_rd = {16'(tx_size_q), rx_ack_q ? 16'd0 : 16'(rx_size_q)};
      9'd8:  reg_rd = {7'd0, prom_q, 7'd0, en_q, port_q};
      9'd9:  reg_rd = phy_status;
      9'd10: reg_rd = phy_q;
      9'd11: reg_rd = {16'd0, rx_cnt_q};
      9'd12: reg_rd = {16'd0, tx_cnt_q};
`ifdef GBE_CPU_IRQ_EN
      9'd13: reg_rd = {30'd0, irq_st_q};
      9'd14: reg_rd = {30'd0, irq_mk_q};
`endif
      default: reg_rd = 32'd0;
    endcase
    mrg = be_merge(reg_rd, wdat_q, be_q);
  end

  // FSM, bus latches, config registers and RX/TX handshakes
  always_comb begin
    state_d = state_q; win_d = win_q; off_d = off_q; rnw_d = rnw_q; err_d = err_q;
    be_d = be_q; wdat_d = wdat_q; mac_d = mac_q; ip_d = ip_q; phy_d = phy_q;
    port_d = port_q; gw_d = gw_q; en_d = en_q; prom_d = prom_q;
    rx_cnt_d = rx_cnt_q; tx_cnt_d = tx_cnt_q; rx_size_d = rx_size_q; tx_size_d = tx_size_q;
    rx_ack_d = rx_ack_q; tx_rdy_d = tx_rdy_q;
    bad = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        win_d = off_in[13:12]; off_d = off_in[10:2]; rnw_d = OPB_RNW;
        be_d = OPB_BE; wdat_d = OPB_DBus;
        bad = off_in[11]
           || ((off_in[13:12] == W_TX || off_in[13:12] == W_RX) &&
               !({1'b0, off_in[10:2]} < 10'(1 << BUF_AW)))
           || ((off_in[13:12] == W_ARP) && !({1'b0, off_in[10:3]} < 9'(1 << ARP_AW)));
        err_d = bad;
        if (bad || off_in[13:12] == W_REG || (off_in[13:12] == W_RX && !OPB_RNW)) state_d = S_ACK;
        else if (OPB_RNW) state_d = S_RD_WAIT;
        else state_d = S_RMW;
      end
      S_RD_WAIT, S_RMW: state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase

    if (reg_wr) begin
      case (off_q)
        9'd0:  mac_d[47:32] = mrg[15:0];
        9'd1:  mac_d[31:0]  = mrg;
        9'd3:  gw_d = mrg[ARP_AW-1:0];
        9'd4:  ip_d = mrg;
        9'd8:  begin port_d = mrg[15:0]; en_d = mrg[16]; prom_d = mrg[24]; end
        9'd10: phy_d = mrg;
        default: ;
      endcase
    end

    // CPU releases the RX buffer by writing 0 to the rx_size half
    if (reg_wr && off_q == 9'd6 && be_q[0] && wdat_q[15:0] == 16'd0) begin
      rx_size_d = '0; rx_ack_d = 1'b1;
    end
    if (rx_latch) begin
      rx_size_d = cpu_rx_size + 1'b1; rx_ack_d = 1'b0; rx_cnt_d = rx_cnt_q + 16'd1;
    end
    // tx_done first so a coincident CPU load overrides it
    if (cpu_tx_done) begin
      tx_size_d = '0; tx_rdy_d = 1'b0; tx_cnt_d = tx_cnt_q + 16'd1;
    end
    if (reg_wr && off_q == 9'd6 && be_q[2]) begin
      tx_size_d = wdat_q[16 +: BUF_AW+3]; tx_rdy_d = 1'b1;
    end
  end

`ifdef GBE_CPU_IRQ_EN
  // Interrupt status: W1C, set events beat a coincident clear
  always_comb begin
    irq_st_d = irq_st_q; irq_mk_d = irq_mk_q;
    if (reg_wr && off_q == 9'd13 && be_q[0]) irq_st_d = irq_st_q & ~wdat_q[1:0];
    if (reg_wr && off_q == 9'd14 && be_q[0]) irq_mk_d = wdat_q[1:0];
    irq_st_d = irq_st_d | {cpu_tx_done, rx_latch};
    irq_d = |(irq_st_d & irq_mk_d);
  end

  // Interrupt state registers
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      irq_st_q <= 2'd0; irq_mk_q <= 2'd0; irq_q <= 1'b0;
    end else begin
      irq_st_q <= irq_st_d; irq_mk_q <= irq_mk_d; irq_q <= irq_d;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // State registers
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= S_IDLE; sel_d_q <= 1'b0; win_q <= 2'd0; off_q <= '0; rnw_q <= 1'b0;
      err_q <= 1'b0; be_q <= 4'd0; wdat_q <= 32'd0;
      mac_q <= LOCAL_MAC; ip_q <= LOCAL_IP; port_q <= LOCAL_PORT; gw_q <= ARP_AW'(LOCAL_GATEWAY);
      en_q <= LOCAL_ENABLE; prom_q <= CPU_PROMISCUOUS; phy_q <= PHY_CONFIG;
      rx_cnt_q <= 16'd0; tx_cnt_q <= 16'd0; rx_size_q <= '0; tx_size_q <= '0;
      rx_ack_q <= 1'b1; tx_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d; sel_d_q <= OPB_select; win_q <= win_d; off_q <= off_d; rnw_q <= rnw_d;
      err_q <= err_d; be_q <= be_d; wdat_q <= wdat_d;
      mac_q <= mac_d; ip_q <= ip_d; port_q <= port_d; gw_q <= gw_d;
      en_q <= en_d; prom_q <= prom_d; phy_q <= phy_d;
      rx_cnt_q <= rx_cnt_d; tx_cnt_q <= tx_cnt_d; rx_size_q <= rx_size_d; tx_size_q <= tx_size_d;
      rx_ack_q <= rx_ack_d; tx_rdy_q <= tx_rdy_d;
    end
  end

  // Read data mux and RMW merge; RAM outputs are valid in the ACK cycle
  always_comb begin
    arp_lo = be_merge(arp_cache_rd_data[31:0], wdat_q, be_q);
    arp_hi = {be_q[1] ? wdat_q[15:8] : arp_cache_rd_data[47:40],
              be_q[0] ? wdat_q[7:0]  : arp_cache_rd_data[39:32]};
    case (win_q)
      W_REG:   rd_mux = reg_rd;
      W_TX:    rd_mux = cpu_tx_buffer_rd_data;
      W_RX:    rd_mux = cpu_rx_buffer_rd_data;
      default: rd_mux = off_q[2] ? arp_cache_rd_data[31:0] : {16'd0, arp_cache_rd_data[47:32]};
    endcase
  end

  assign Sl_DBus    = (xfer && rnw_q) ? rd_mux : 32'd0;
  assign Sl_xferAck = xfer;
  assign Sl_errAck  = ack_cyc && err_q;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign cpu_tx_buffer_addr    = off_q[BUF_AW+1:2];
  assign cpu_rx_buffer_addr    = off_q[BUF_AW+1:2];
  assign arp_cache_addr        = off_q[ARP_AW+2:3];
  assign cpu_tx_buffer_wr_en   = wr_cyc && (win_q == W_TX);
  assign cpu_tx_buffer_wr_data = be_merge(cpu_tx_buffer_rd_data, wdat_q, be_q);
  assign arp_cache_wr_en       = wr_cyc && (win_q == W_ARP);
  assign arp_cache_wr_data     = off_q[2] ? {arp_cache_rd_data[47:32], arp_lo}
                                          : {arp_hi, arp_cache_rd_data[31:0]};

  assign local_enable    = en_q;
  assign local_mac       = mac_q;
  assign local_ip        = ip_q;
  assign local_port      = port_q;
  assign local_gateway   = gw_q;
  assign cpu_promiscuous = prom_q;
  assign phy_control     = phy_q;
  assign cpu_rx_ack      = rx_ack_q;
  assign cpu_tx_size     = tx_size_q;
  assign cpu_tx_ready    = tx_rdy_q;

endmodule

// File: tb/tb_gbe_cpu_attach_v2.sv
// Directed bench for gbe_cpu_attach_v2 with RAM models and a response scoreboard.
module tb_gbe_cpu_attach_v2;
  localparam int BUF_AW = 9;
  localparam int ARP_AW = 4;
`ifdef GBE_CPU_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic OPB_Clk = 1'b0, OPB_Rst = 1'b1, OPB_RNW = 1'b0, OPB_select = 1'b0;
  logic [3:0] OPB_BE = 4'd0;
  logic [31:0] OPB_ABus = 32'd0, OPB_DBus = 32'd0;
  logic [31:0] Sl_DBus;
  logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic local_enable, cpu_promiscuous;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic [15:0] local_port;
  logic [ARP_AW-1:0] local_gateway, arp_cache_addr;
  logic [47:0] arp_cache_rd_data, arp_cache_wr_data;
  logic arp_cache_wr_en;
  logic [BUF_AW-1:0] cpu_rx_buffer_addr, cpu_tx_buffer_addr;
  logic [31:0] cpu_rx_buffer_rd_data, cpu_tx_buffer_rd_data, cpu_tx_buffer_wr_data;
  logic [BUF_AW+2:0] cpu_rx_size = '0, cpu_tx_size;
  logic cpu_rx_ready = 1'b0, cpu_rx_ack, cpu_tx_buffer_wr_en, cpu_tx_ready, cpu_tx_done = 1'b0;
  logic [31:0] phy_status = 32'h1234_5678, phy_control;
  logic irq;

  gbe_cpu_attach_v2 #(.ARP_AW(ARP_AW), .BUF_AW(BUF_AW)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_BE(OPB_BE), .OPB_ABus(OPB_ABus), .OPB_DBus(OPB_DBus),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .local_enable(local_enable), .local_mac(local_mac), .local_ip(local_ip),
    .local_port(local_port), .local_gateway(local_gateway), .cpu_promiscuous(cpu_promiscuous),
    .arp_cache_addr(arp_cache_addr), .arp_cache_rd_data(arp_cache_rd_data),
    .arp_cache_wr_data(arp_cache_wr_data), .arp_cache_wr_en(arp_cache_wr_en),
    .cpu_rx_buffer_addr(cpu_rx_buffer_addr), .cpu_rx_buffer_rd_data(cpu_rx_buffer_rd_data),
    .cpu_rx_size(cpu_rx_size), .cpu_rx_ready(cpu_rx_ready), .cpu_rx_ack(cpu_rx_ack),
    .cpu_tx_buffer_addr(cpu_tx_buffer_addr), .cpu_tx_buffer_rd_data(cpu_tx_buffer_rd_data),
    .cpu_tx_buffer_wr_data(cpu_tx_buffer_wr_data), .cpu_tx_buffer_wr_en(cpu_tx_buffer_wr_en),
    .cpu_tx_size(cpu_tx_size), .cpu_tx_ready(cpu_tx_ready), .cpu_tx_done(cpu_tx_done),
    .phy_status(phy_status), .phy_control(phy_control), .irq(irq)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  // Registered-read RAM models; preloaded while reset is held
  logic [31:0] tx_mem [0:(1<<BUF_AW)-1];
  logic [47:0] arp_mem [0:(1<<ARP_AW)-1];
  always @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      tx_mem[1]  <= 32'h1122_3344;
      arp_mem[2] <= 48'h1111_2222_3333;
    end else begin
      if (cpu_tx_buffer_wr_en) tx_mem[cpu_tx_buffer_addr] <= cpu_tx_buffer_wr_data;
      if (arp_cache_wr_en) arp_mem[arp_cache_addr] <= arp_cache_wr_data;
    end
    cpu_tx_buffer_rd_data <= tx_mem[cpu_tx_buffer_addr];
    arp_cache_rd_data     <= arp_mem[arp_cache_addr];
    cpu_rx_buffer_rd_data <= {16'hA5A5, 7'd0, cpu_rx_buffer_addr};
  end

  int tx_we_cnt = 0;
  always @(posedge OPB_Clk) if (cpu_tx_buffer_wr_en) tx_we_cnt <= tx_we_cnt + 1;

  typedef struct { logic err; logic chk; logic [31:0] d; } exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  logic snap_twe, snap_awe;
  logic [BUF_AW-1:0] snap_taddr;
  logic [31:0] snap_twd;
  logic [47:0] snap_awd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One OPB transfer; exp_lat=0 means no ack is expected at all
  task automatic xfer(input string tag, input logic rnw, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd, input bit done_at_ack);
    int lat, i;
    exp_t e;
    logic xa, ea;
    logic [31:0] db;
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = addr; OPB_BE = be; OPB_DBus = wd;
    if (exp_lat > 0) exp_q.push_back('{exp_err, rnw || exp_err, exp_err ? 32'd0 : exp_rd});
    lat = 0; i = 0;
    while (lat == 0 && i < 6) begin
      @(negedge OPB_Clk); i++;
      if (Sl_xferAck || Sl_errAck) lat = i;
    end
    xa = Sl_xferAck; ea = Sl_errAck; db = Sl_DBus;
    snap_twe = cpu_tx_buffer_wr_en; snap_awe = arp_cache_wr_en;
    snap_taddr = cpu_tx_buffer_addr; snap_twd = cpu_tx_buffer_wr_data; snap_awd = arp_cache_wr_data;
    if (done_at_ack) cpu_tx_done = 1'b1;
    OPB_select = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (lat > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " errAck"}, 64'(ea), 64'(e.err));
      chk({tag, " xferAck"}, 64'(xa), 64'(!e.err));
      if (e.chk) chk({tag, " data"}, 64'(db), 64'(e.d));
    end
    @(negedge OPB_Clk);
    cpu_tx_done = 1'b0;
    chk({tag, " ack pulse ends"}, {31'd0, Sl_xferAck, Sl_errAck, Sl_DBus}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge OPB_Clk);
    chk("rst mac", 64'(local_mac), 64'h0000_FFFF_FFFF_FFFF);
    chk("rst rx_ack", 64'(cpu_rx_ack), 64'd1);
    chk("rst irq", 64'(irq), 64'd0);
    chk("rst tx_ready", 64'(cpu_tx_ready), 64'd0);
    chk("rst acks", {62'd0, Sl_xferAck, Sl_errAck}, 64'd0);
    OPB_Rst = 1'b0;

    xfer("rd reg1", 1, 32'h0004, 4'hF, 0, 1, 0, 32'hFFFF_FFFF, 0);

    // TX byte-lane RMW
    xfer("tx rmw", 0, 32'h1004, 4'b0011, 32'hDEAD_BEEF, 2, 0, 0, 0);
    chk("tx wr_en", 64'(snap_twe), 64'd1);
    chk("tx wr addr", 64'(snap_taddr), 64'd1);
    chk("tx wr data", 64'(snap_twd), 64'h1122_BEEF);
    xfer("tx readback", 1, 32'h1004, 4'hF, 0, 2, 0, 32'h1122_BEEF, 0);

    // ARP lo-word RMW and hi-word readback
    xfer("arp rmw", 0, 32'h3014, 4'hF, 32'hCAFE_F00D, 2, 0, 0, 0);
    chk("arp wr_en", 64'(snap_awe), 64'd1);
    chk("arp wr data", 64'(snap_awd), 64'h0000_1111_CAFE_F00D);
    xfer("arp rd hi", 1, 32'h3010, 4'hF, 0, 2, 0, 32'h0000_1111, 0);
    xfer("arp rd lo", 1, 32'h3014, 4'hF, 0, 2, 0, 32'hCAFE_F00D, 0);

    // RX buffer read and ignored write
    xfer("rx rd", 1, 32'h2008, 4'hF, 0, 2, 0, 32'hA5A5_0002, 0);
    xfer("rx wr", 0, 32'h2000, 4'hF, 32'h5555_5555, 1, 0, 0, 0);
    chk("rx wr no tx_we", 64'(snap_twe), 64'd0);

    // Interrupt mask, then RX handshake
    xfer("wr mask", 0, 32'h0038, 4'b0001, 32'h3, 1, 0, 0, 0);
    @(negedge OPB_Clk);
    cpu_rx_size = 12'd63; cpu_rx_ready = 1'b1;
    @(negedge OPB_Clk);
    cpu_rx_ready = 1'b0;
    chk("rx ack dropped", 64'(cpu_rx_ack), 64'd0);
    chk("irq on rx", 64'(irq), 64'(IRQ_ON));
    xfer("rd sizes", 1, 32'h0018, 4'hF, 0, 1, 0, 32'h0000_0040, 0);
    xfer("rd rx_count", 1, 32'h002C, 4'hF, 0, 1, 0, 32'd1, 0);
    xfer("rd mask", 1, 32'h0038, 4'hF, 0, 1, 0, IRQ_ON ? 32'd3 : 32'd0, 0);
    xfer("w1c status", 0, 32'h0034, 4'b0001, 32'h1, 1, 0, 0, 0);
    chk("irq cleared", 64'(irq), 64'd0);
    xfer("rd status", 1, 32'h0034, 4'hF, 0, 1, 0, 32'd0, 0);
    xfer("rx release", 0, 32'h0018, 4'b0001, 32'h0, 1, 0, 0, 0);
    chk("rx ack back", 64'(cpu_rx_ack), 64'd1);
    xfer("rd sizes 0", 1, 32'h0018, 4'hF, 0, 1, 0, 32'd0, 0);

    // TX handshake, including CPU write colliding with tx_done
    xfer("tx load", 0, 32'h0018, 4'b1100, 32'h0040_0000, 1, 0, 0, 0);
    chk("tx size 64", 64'(cpu_tx_size), 64'd64);
    chk("tx ready", 64'(cpu_tx_ready), 64'd1);
    xfer("tx load+done", 0, 32'h0018, 4'b1100, 32'h0020_0000, 1, 0, 0, 1);
    chk("tx size 32", 64'(cpu_tx_size), 64'd32);
    chk("tx ready kept", 64'(cpu_tx_ready), 64'd1);
    xfer("rd tx_count 1", 1, 32'h0030, 4'hF, 0, 1, 0, 32'd1, 0);
    @(negedge OPB_Clk); cpu_tx_done = 1'b1;
    @(negedge OPB_Clk); cpu_tx_done = 1'b0;
    chk("tx done size", 64'(cpu_tx_size), 64'd0);
    chk("tx done ready", 64'(cpu_tx_ready), 64'd0);
    chk("irq on tx", 64'(irq), 64'(IRQ_ON));
    xfer("rd tx_count 2", 1, 32'h0030, 4'hF, 0, 1, 0, 32'd2, 0);

    // phy registers
    xfer("phy byte wr", 0, 32'h0028, 4'b0101, 32'hAABB_CCDD, 1, 0, 0, 0);
    chk("phy_control", 64'(phy_control), 64'h00BB_00DD);
    xfer("rd phy_status", 1, 32'h0024, 4'hF, 0, 1, 0, 32'h1234_5678, 0);

    // Address errors and out-of-range
    xfer("err 0x800", 1, 32'h0800, 4'hF, 0, 1, 1, 0, 0);
    xfer("err tx gap", 0, 32'h1800, 4'hF, 32'h1, 1, 1, 0, 0);
    chk("err tx no we", 64'(snap_twe), 64'd0);
    xfer("err arp depth", 0, 32'h3080, 4'hF, 32'h1, 1, 1, 0, 0);
    chk("err arp no we", 64'(snap_awe), 64'd0);
    xfer("out of range", 1, 32'h4000, 4'hF, 0, 0, 0, 0, 0);

    // Reset during RMW: no write may escape
    begin
      int we0;
      we0 = tx_we_cnt;
      @(negedge OPB_Clk);
      OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = 32'h1008; OPB_BE = 4'hF; OPB_DBus = 32'h7777_7777;
      @(negedge OPB_Clk);
      OPB_Rst = 1'b1; OPB_select = 1'b0;
      repeat (3) @(negedge OPB_Clk);
      OPB_Rst = 1'b0;
      repeat (2) @(negedge OPB_Clk);
      chk("rst mid-rmw we", 64'(tx_we_cnt), 64'(we0));
      chk("rst mid-rmw ack", 64'(Sl_xferAck), 64'd0);
      chk("rst mid-rmw rx_ack", 64'(cpu_rx_ack), 64'd1);
      chk("rst mid-rmw irq", 64'(irq), 64'd0);
    end
    xfer("rd after rst", 1, 32'h1008, 4'hF, 0, 2, 0, tx_mem[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
